// File: rtl/mem_host_bridge.sv
// Host-side bridge for the processor data memory: loads an input image, runs the
// processor via START/DONE with an optional cycle timeout, then drains the results.
module mem_host_bridge #(
  parameter int ADDR_W      = 8,
  parameter int LOAD_BASE   = 0,
  parameter int LOAD_LEN    = 64,
  parameter int RESULT_BASE = 64,
  parameter int RESULT_LEN  = 8,
  parameter int TIMEOUT     = 4096
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              host_valid,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              mem_own,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              START,
  input  logic              DONE,
  output logic              busy,
  output logic              timeout_err
);

  localparam int RUN_W = ($clog2(TIMEOUT) + 1 > 16) ? $clog2(TIMEOUT) + 1 : 16;

  localparam logic [ADDR_W-1:0] LD_LAST   = ADDR_W'(LOAD_LEN - 1);
  localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(RESULT_LEN - 1);
  localparam logic [ADDR_W-1:0] LD_BASE_A = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RESULT_BASE);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ld_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [RUN_W-1:0]  run_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= S_LOAD;
      ld_cnt      <= '0;
      rd_cnt      <= '0;
      run_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (host_valid) begin
            if (ld_cnt == LD_LAST) begin
              ld_cnt <= '0;
              state  <= S_HOLD;
            end else begin
              ld_cnt <= ld_cnt + ADDR_W'(1);
            end
          end
        end
        S_HOLD: begin
          run_cnt     <= '0;
          timeout_err <= 1'b0;
          state       <= S_RUN;
        end
        S_RUN: begin
          if (run_cnt != '1) run_cnt <= run_cnt + RUN_W'(1);
          // DONE in the first RUN cycle may be stale from the previous run.
          if (run_cnt != '0 && DONE) begin
            rd_cnt <= '0;
            state  <= S_DRAIN;
          end else if (TIMEOUT != 0 && run_cnt == RUN_LAST) begin
            timeout_err <= 1'b1;
            rd_cnt      <= '0;
            state       <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (rd_cnt == RD_LAST) begin
              rd_cnt <= '0;
              state  <= S_LOAD;
            end else begin
              rd_cnt <= rd_cnt + ADDR_W'(1);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    START      = 1'b1;
    mem_own    = 1'b1;
    host_ready = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    busy       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    unique case (state)
      S_LOAD: begin
        // Reset gates the handshake directly so no write can slip through
        // while the asynchronous reset is still asserted.
        host_ready = !reset;
        mem_we     = host_valid && !reset;
        mem_addr   = LD_BASE_A + ld_cnt;
        mem_wdata  = host_data;
      end
      S_RUN: begin
        START   = 1'b0;
        mem_own = 1'b0;
        busy    = 1'b1;
      end
      S_DRAIN: begin
        mem_re    = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_rdata;
        mem_addr  = RD_BASE_A + rd_cnt;
      end
      default: ;
    endcase
  end

endmodule
